// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: walks base+k*stride (or base+bitrev(k) with BRS_BITREV_EN) over a 1-cycle BRAM read port and streams the words out over valid/ready with a FIFO; ports: i_start/i_base_addr/i_stride/i_length[/i_bitrev] in, o_rd_addr/i_rd_dout BRAM, o_m_data/o_m_valid/o_m_last/i_m_ready stream, o_busy/o_done status
module bram_rd_streamer #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int LOG_N = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic [ADDR_W:0]   i_length,
`ifdef BRS_BITREV_EN
  input  logic              i_bitrev,
`endif
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_dout,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last,
  output logic              o_busy,
  output logic              o_done
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 3) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state;
  logic [ADDR_W:0] r_len, r_cnt;
  logic [ADDR_W-1:0] r_base, r_stride, r_next, r_rd_addr, w_brev, w_addr;
  logic [DATA_W:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [OW-1:0] r_occ;
  logic r_v1, r_v2, r_l1, r_l2, r_busy, r_done;
  logic w_rev, w_start, w_issue, w_last, w_pop, w_room;
`ifdef BRS_BITREV_EN
  logic r_rev;
  always_ff @(posedge clk)
    if (rst) r_rev <= 1'b0;
    else if (w_start) r_rev <= i_bitrev;
  assign w_rev = r_rev;
`else
  assign w_rev = 1'b0;
`endif
  always_comb begin
    w_brev = '0;
    for (int i = 0; i < LOG_N; i++) w_brev[i] = r_cnt[LOG_N-1-i];
  end
  assign w_start = i_start && r_state == IDLE;
  assign o_m_valid = r_occ != '0;
  assign w_pop = o_m_valid && i_m_ready;
  assign w_room = r_occ + OW'(r_v1) + OW'(r_v2) < OW'(FIFO_DEPTH) + OW'(w_pop);
  assign w_last = w_start ? i_length == (ADDR_W+1)'(1) : r_cnt == r_len - (ADDR_W+1)'(1);
  assign w_issue = w_start ? i_length != '0 : r_state == RUN && r_cnt != r_len && w_room;
  assign w_addr = w_start ? i_base_addr : w_rev ? r_base + w_brev : r_next;
  assign o_rd_addr = r_rd_addr;
  assign o_m_data = r_mem[r_rp][DATA_W-1:0];
  assign o_m_last = o_m_valid && r_mem[r_rp][DATA_W];
  assign o_busy = r_busy;
  assign o_done = r_done;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_len <= '0;
      r_cnt <= '0;
      r_base <= '0;
      r_stride <= '0;
      r_next <= '0;
      r_rd_addr <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_occ <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_v1 <= w_issue;
      r_l1 <= w_issue && w_last;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      if (w_issue) r_rd_addr <= w_addr;
      if (w_start) begin
        r_base <= i_base_addr;
        r_stride <= i_stride;
        r_len <= i_length;
        r_cnt <= (ADDR_W+1)'(1);
        r_next <= i_base_addr + i_stride;
      end else if (w_issue) begin
        r_cnt <= r_cnt + (ADDR_W+1)'(1);
        r_next <= r_next + r_stride;
      end
      if (r_v2) begin
        r_mem[r_wp] <= {r_l2, i_rd_dout};
        r_wp <= r_wp == PW'(FIFO_DEPTH - 1) ? '0 : r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp == PW'(FIFO_DEPTH - 1) ? '0 : r_rp + PW'(1);
      r_occ <= r_occ + OW'(r_v2) - OW'(w_pop);
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= i_length == '0 ? DONE : RUN;
          r_busy <= i_length != '0;
          r_done <= i_length == '0;
        end
        RUN: if ((w_issue && w_last) || r_cnt == r_len) r_state <= DRAIN;
        DRAIN: if (w_pop && o_m_last) begin
          r_state <= DONE;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done <= 1'b0;
        end
      endcase
    end
endmodule
